// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data memory controller.
// Holds FSM states, access size codes and the access fault check.
package data_memory_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    function automatic logic access_fault(
        input logic        rd,
        input logic        wr,
        input logic [1:0]  sz,
        input logic [63:0] addr,
        input logic [63:0] off_mask,
        input logic [63:0] limit
    );
        logic f;
        f = rd & wr;
        f = f | (sz == SZ_RSVD);
        f = f | ((sz == SZ_HALF) & addr[0]);
        f = f | ((sz == SZ_WORD) & ((addr & off_mask) != 64'd0));
        f = f | (addr >= limit);
        return f;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_mem_lane_align.sv
// Byte-lane steering between the CPU data path and a storage word.
// Stores merge lanes into the old word; loads extract and extend.
module mem_lane_align
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFFW       = 2
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [OFFW-1:0]       offset,
    output logic [DATA_WIDTH-1:0] merged,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [OFFW+2:0]       sh;
    logic [DATA_WIDTH-1:0] bmask;
    logic [15:0]           lane;
    logic                  sx8;
    logic                  sx16;

    assign sh   = {offset, 3'b000};
    assign lane = 16'(old_word >> sh);
    assign sx8  = ~is_unsigned & lane[7];
    assign sx16 = ~is_unsigned & lane[15];

    // Lane mask and merged store word.
    always_comb begin
        bmask = '1;
        unique case (size)
            SZ_BYTE: bmask = DATA_WIDTH'(8'hFF) << sh;
            SZ_HALF: bmask = DATA_WIDTH'(16'hFFFF) << sh;
            default: bmask = '1;
        endcase
        merged = (old_word & ~bmask) | ((wdata << sh) & bmask);
    end

    // Load extraction with sign or zero extension.
    always_comb begin
        load_data = old_word;
        unique case (size)
            SZ_BYTE: load_data = {{(DATA_WIDTH-8){sx8}}, lane[7:0]};
            SZ_HALF: load_data = {{(DATA_WIDTH-16){sx16}}, lane};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with sized accesses and wait states.
// Clears itself after reset or on request; reports rejected accesses.
module data_memory_ctrl
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic                  ClearStart,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Ready,
    output logic                  Busy,
    output logic                  Fault
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);
    localparam logic [63:0] LIMIT    = 64'(DEPTH) * 64'(BYTES);
    localparam logic [63:0] OFF_MASK = 64'(BYTES - 1);
    localparam logic [3:0]  WS_INIT  =
        4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

    state_t state;
    state_t state_nx;

    logic [IDXW-1:0]       clr_cnt;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  rd_q;
    logic                  wr_q;

    logic [ADDR_WIDTH-1:0] e_addr;
    logic [DATA_WIDTH-1:0] e_wdata;
    logic [1:0]            e_size;
    logic                  e_uns;
    logic                  e_rd;
    logic                  e_wr;

    logic                  accept;
    logic                  access;
    logic                  fault_now;
    logic [IDXW-1:0]       idx;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] load_data;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ready_q;
    logic                  fault_q;

    // Live inputs in IDLE (zero-wait access), latched copy otherwise.
    always_comb begin
        e_addr  = addr_q;
        e_wdata = wdata_q;
        e_size  = size_q;
        e_uns   = uns_q;
        e_rd    = rd_q;
        e_wr    = wr_q;
        if (state == IDLE) begin
            e_addr  = Address;
            e_wdata = WriteData;
            e_size  = Size;
            e_uns   = Unsigned;
            e_rd    = MemRead;
            e_wr    = MemWrite;
        end
    end

    assign fault_now = access_fault(e_rd, e_wr, e_size,
                                    64'(e_addr), OFF_MASK, LIMIT);
    assign idx      = e_addr[OFFW +: IDXW];
    assign old_word = mem[idx];

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFFW       (OFFW)
    ) u_align (
        .old_word    (old_word),
        .wdata       (e_wdata),
        .size        (e_size),
        .is_unsigned (e_uns),
        .offset      (e_addr[OFFW-1:0]),
        .merged      (merged),
        .load_data   (load_data)
    );

    // Next state; access marks the edge that enters DONE.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        access   = 1'b0;
        unique case (state)
            CLEAR: begin
                if (clr_cnt == LAST) state_nx = IDLE;
            end
            IDLE: begin
                if (ClearStart) begin
                    state_nx = CLEAR;
                end else if (MemRead | MemWrite) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nx = DONE;
                        access   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nx = DONE;
                    access   = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    // State, counters, request latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= SZ_BYTE;
            uns_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= access;
            fault_q <= access & fault_now;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
            else                clr_cnt <= '0;
            if (accept) begin
                wait_cnt <= WS_INIT;
                addr_q   <= Address;
                wdata_q  <= WriteData;
                size_q   <= Size;
                uns_q    <= Unsigned;
                rd_q     <= MemRead;
                wr_q     <= MemWrite;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (access && e_rd && !fault_now) rdata_q <= load_data;
        end
    end

    // Storage array: sweep writes zero, good stores write merged word.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (access && e_wr && !e_rd && !fault_now) begin
                mem[idx] <= merged;
            end
        end
    end

    assign ReadData = rdata_q;
    assign Ready    = ready_q;
    assign Fault    = fault_q;
    assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with default parameters.
// Vector table for single accesses plus hand sequences for sweeps/reset.
module tb_data_memory_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic        ClearStart;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Busy;
    logic        Fault;

    int n_cmp = 0;
    int n_bad = 0;

    data_memory_ctrl #(
        .DATA_WIDTH  (32),
        .DEPTH       (256),
        .WAIT_STATES (2),
        .ADDR_WIDTH  (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Size       (Size),
        .Unsigned   (Unsigned),
        .ClearStart (ClearStart),
        .ReadData   (ReadData),
        .Ready      (Ready),
        .Busy       (Busy),
        .Fault      (Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_flt;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (Busy && n < 2000);
        if (Busy) check("wait_idle_timeout", 32'(Busy), 32'd0);
    endtask

    task automatic wait_clear(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (Busy && cyc < 1000);
    endtask

    task automatic access(input logic rd, input logic wr,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic flt,
                          output int lat);
        wait_idle();
        MemRead   = rd;
        MemWrite  = wr;
        Size      = sz;
        Unsigned  = uns;
        Address   = addr;
        WriteData = wd;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!Ready && lat < 20);
        rdata = ReadData;
        flt   = Fault;
    endtask

    task automatic load_chk(input string name, input logic [31:0] addr,
                            input logic [31:0] exp);
        logic [31:0] rd;
        logic        f;
        int          l;
        access(1'b1, 1'b0, 2'b10, 1'b0, addr, 32'h0, rd, f, l);
        check({name, "_rdata"}, rd, exp);
        check({name, "_fault"}, 32'(f), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        f;
        int          l;
        int          cyc;
        int          t;
        int          first;
        int          second;

        tbl[0]  = '{1, 0, 2'b10, 0, 32'h08, 32'h0, 32'h00000000, 0};
        tbl[1]  = '{0, 1, 2'b10, 0, 32'h10, 32'h87654321, 32'h0, 0};
        tbl[2]  = '{1, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF87, 0};
        tbl[3]  = '{1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000087, 0};
        tbl[4]  = '{1, 0, 2'b01, 0, 32'h10, 32'h0, 32'h00004321, 0};
        tbl[5]  = '{0, 1, 2'b00, 0, 32'h11, 32'hAB, 32'h00004321, 0};
        tbl[6]  = '{1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8765AB21, 0};
        tbl[7]  = '{1, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8765, 0};
        tbl[8]  = '{1, 0, 2'b10, 0, 32'h12, 32'h0, 32'hFFFF8765, 1};
        tbl[9]  = '{0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF,
                    32'hFFFF8765, 1};
        tbl[10] = '{1, 1, 2'b10, 0, 32'h10, 32'h11111111,
                    32'hFFFF8765, 1};
        tbl[11] = '{1, 0, 2'b10, 0, 32'h400, 32'h0, 32'hFFFF8765, 1};
        tbl[12] = '{0, 1, 2'b10, 0, 32'h400, 32'h5A5A5A5A,
                    32'hFFFF8765, 1};
        tbl[13] = '{1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h8765AB21, 0};
        tbl[14] = '{0, 1, 2'b01, 0, 32'h16, 32'hFFFFBEEF,
                    32'h8765AB21, 0};
        tbl[15] = '{1, 0, 2'b10, 0, 32'h14, 32'h0, 32'hBEEF0000, 0};
        tbl[16] = '{1, 0, 2'b01, 1, 32'h16, 32'h0, 32'h0000BEEF, 0};
        tbl[17] = '{1, 0, 2'b01, 0, 32'h13, 32'h0, 32'h0000BEEF, 1};

        rst_n      = 1'b0;
        Address    = '0;
        WriteData  = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Size       = 2'b10;
        Unsigned   = 1'b0;
        ClearStart = 1'b0;
        #1;
        check("rst_busy", 32'(Busy), 32'd1);
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_fault", 32'(Fault), 32'd0);
        check("rst_rdata", ReadData, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_clear(cyc);
        check("init_sweep_cycles", 32'(cyc), 32'd256);

        for (int i = 0; i < 18; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns,
                   tbl[i].addr, tbl[i].wdata, rd, f, l);
            check($sformatf("vec%0d_latency", i), 32'(l), 32'd3);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_fault", i), 32'(f),
                  32'(tbl[i].exp_flt));
        end

        wait_idle();
        MemRead = 1'b1;
        Size    = 2'b10;
        Address = 32'h10;
        t = 0;
        first = -1;
        second = -1;
        while (second < 0 && t < 40) begin
            @(negedge clk);
            t++;
            if (Ready) begin
                if (first < 0) first = t;
                else           second = t;
            end
        end
        MemRead = 1'b0;
        check("b2b_period", 32'(second - first), 32'd4);
        check("b2b_rdata", ReadData, 32'h8765AB21);

        wait_idle();
        ClearStart = 1'b1;
        @(posedge clk);
        #1;
        ClearStart = 1'b0;
        wait_clear(cyc);
        check("clear_sweep_cycles", 32'(cyc), 32'd256);
        load_chk("clear_0x10", 32'h10, 32'h0);

        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h99, rd, f, l);
        load_chk("pre_0x10", 32'h10, 32'h99);
        wait_idle();
        ClearStart = 1'b1;
        MemWrite   = 1'b1;
        Size       = 2'b10;
        Address    = 32'h20;
        WriteData  = 32'h55;
        @(posedge clk);
        #1;
        ClearStart = 1'b0;
        MemWrite   = 1'b0;
        wait_clear(cyc);
        check("clr_req_sweep_cycles", 32'(cyc), 32'd256);
        load_chk("clr_req_0x20", 32'h20, 32'h0);
        load_chk("clr_req_0x10", 32'h10, 32'h0);

        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, rd, f, l);
        load_chk("pre_rst_0x24", 32'h24, 32'hCAFEF00D);
        wait_idle();
        MemWrite  = 1'b1;
        Size      = 2'b10;
        Address   = 32'h20;
        WriteData = 32'h12345678;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rdata", ReadData, 32'd0);
        check("midrst_ready", 32'(Ready), 32'd0);
        check("midrst_fault", 32'(Fault), 32'd0);
        check("midrst_busy", 32'(Busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear(cyc);
        check("midrst_sweep_cycles", 32'(cyc), 32'd256);
        load_chk("midrst_0x20", 32'h20, 32'h0);
        load_chk("midrst_0x24", 32'h24, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
